reorder_buffer_mp: RTL and testbench
====================================

// Module: reorder_buffer_mp
// PURPOSE
//  Parametrised in-order-commit reorder buffer, successor to the single-config ROB. Sits between IF/issue and
//  RS/LSB: allocates one tag per issued instruction, resolves LUI/AUIPC/JAL at issue, accepts NUM_WB
//  parallel result writebacks, serves two combinational operand-forwarding queries, commits one entry/cycle to CDB.
//  Explicit occupancy counter replaces wrap flag; whole-buffer flush on mispredict.
// PARAMETERS
//  DEPTH   16  entries; power of two, >=2
//  IDX_W   4   tag width, = log2(DEPTH)
//  NUM_WB  3   writeback ports (ALU1, ALU2, LSB)
//  XLEN    32  data width
// PORTS
//  clk             in  1              clock, all state on posedge
//  rst             in  1              synchronous, active-high reset
//  rdy             in  1              0 = freeze: no state change, outputs hold
//  issue_valid     in  1              IF presents instruction
//  issue_ins       in  32             instruction word
//  issue_pc        in  32             its PC
//  rob_full        out 1              comb: count==DEPTH
//  issue_tag       out IDX_W          comb: tag the next issue receives (= tail)
//  disp_valid      out 1              reg: 1-cycle pulse, instruction forwarded to RS
//  disp_ins        out 32             reg: instruction word
//  disp_tag        out IDX_W          reg: its ROB tag
//  disp_rd         out 5              reg: renamed dest reg (0 for BRANCH/STORE)
//  disp_is_ls      out 1              reg: LOAD/STORE, LSB must enqueue disp_tag
//  wb_valid        in  NUM_WB         per-port result valid
//  wb_tag          in  NUM_WB*IDX_W   port p at [p*IDX_W +: IDX_W]
//  wb_value        in  NUM_WB*XLEN    port p at [p*XLEN +: XLEN]
//  qry_tag_a/b     in  IDX_W          operand lookup tags
//  qry_ready_a/b   out 1              comb: entry busy and result written
//  qry_value_a/b   out XLEN           comb: entry value (don't-care when not ready)
//  flush           in  1              mispredict: discard all entries
//  commit_valid    out 1              reg: 1-cycle commit pulse
//  commit_tag      out IDX_W          reg
//  commit_dest     out 5              reg
//  commit_value    out XLEN           reg
//  commit_pc       out 32             reg: PC of committed entry
//  commit_is_branch out 1             reg
//  commit_is_jalr  out 1              reg
//  count           out IDX_W+1        reg: occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at posedge): head=tail=count=0, all busy/ready=0, every registered output 0. Wins over rdy/flush.
//  Per entry: busy, ready, dest[4:0], value, pc, is_branch, is_jalr. Tags = entry index; head/tail wrap mod DEPTH.
//  Issue accepted iff issue_valid && !rob_full (registered count); else ignored (IF must gate). Accept:
//   entry[tail] busy=1, tail+=1, pc/dest stored; dest=0 for BRANCH(1100011)/STORE(0100011).
//   LUI: value={ins[31:12],12'b0}; AUIPC: pc+{ins[31:12],12'b0}; JAL: pc+4 -> ready=1 at issue, no dispatch.
//   Else ready=0, disp_* loaded next cycle, disp_is_ls=1 for LOAD(0000011)/STORE. No accept -> disp_valid=0.
//  Writeback: each valid port sets ready=1, value=wb_value on wb_tag, only if entry busy && !ready (else ignored).
//   Same tag on several ports: highest port index wins. Never targets the entry issued that cycle.
//  Commit: when count!=0 && ready[head] (registered state) -> commit_* loaded from head, busy[head]=0, head+=1.
//   Writeback to head in cycle N -> commit_valid in cycle N+1 at earliest. Otherwise commit_valid=0.
//  count_next = count + issue_acc - commit; simultaneous issue+commit leaves count unchanged (incl. wrap at DEPTH-1).
//   Full: issue blocked even if commit occurs same cycle. Empty: no commit.
//  Queries purely combinational over registered state; no bypass of same-cycle wb_*.
//  flush (rdy=1): head=tail=count=0, all busy/ready=0, disp_valid=commit_valid=0 next cycle; same-cycle issue,
//   writeback and commit discarded. Other disp_*/commit_* data hold.
//  rdy=0: all inputs ignored, no state/output change, pulses stay at current value.
// TESTING
//  Reset then issue LUI x5,0x12345 at pc 0x100 -> commit_valid 2 cycles later, commit_dest=5, commit_value=0x12345000.
//  AUIPC x1,1 at pc 0x1000 -> commit_value=0x2000; JAL x1 at pc 0x20 -> commit_value=0x24, no disp_valid.
//  Issue 16 ADDs, no wb -> rob_full=1, count=16, 17th issue ignored; wb tag 0 -> commit tag 0, count 15, rob_full=0.
//  wb tag 3 on ports 0 and 2 same cycle (0xAAAA / 0xBBBB) -> qry_value_a(tag3)=0xBBBB, qry_ready_a=1, in-order commit.
//  Tail/head wrap: 40 issue+wb+commit cycles -> tags commit 0..15,0..15,0..7 in order, count steady.
//  8 entries live, flush with issue_valid and wb_valid asserted -> count=0, no commit/dispatch next cycle, issue_tag=0.

Source files
------------

// File: rtl/reorder_buffer_mp.sv
// In-order-commit reorder buffer: issue-time immediate resolution, multi-port
// writeback, two operand queries, one commit per cycle, whole-buffer flush.
module reorder_buffer_mp #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    issue_valid,
    input  logic [31:0]             issue_ins,
    input  logic [31:0]             issue_pc,
    output logic                    rob_full,
    output logic [IDX_W-1:0]        issue_tag,
    output logic                    disp_valid,
    output logic [31:0]             disp_ins,
    output logic [IDX_W-1:0]        disp_tag,
    output logic [4:0]              disp_rd,
    output logic                    disp_is_ls,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*IDX_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]  wb_value,
    input  logic [IDX_W-1:0]        qry_tag_a,
    input  logic [IDX_W-1:0]        qry_tag_b,
    output logic                    qry_ready_a,
    output logic                    qry_ready_b,
    output logic [XLEN-1:0]         qry_value_a,
    output logic [XLEN-1:0]         qry_value_b,
    input  logic                    flush,
    output logic                    commit_valid,
    output logic [IDX_W-1:0]        commit_tag,
    output logic [4:0]              commit_dest,
    output logic [XLEN-1:0]         commit_value,
    output logic [31:0]             commit_pc,
    output logic                    commit_is_branch,
    output logic                    commit_is_jalr,
    output logic [IDX_W:0]          count
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    logic [DEPTH-1:0] busy, ready, is_br, is_jr;
    logic [4:0]       dest  [DEPTH];
    logic [XLEN-1:0]  value [DEPTH];
    logic [31:0]      pc_q  [DEPTH];
    logic [IDX_W-1:0] head, tail;

    logic [6:0]      op;
    logic [31:0]     upper;
    logic            imm_op, issue_acc, do_commit;
    logic [XLEN-1:0] imm_val;
    logic [4:0]      rd_eff;

    assign op        = issue_ins[6:0];
    assign upper     = {issue_ins[31:12], 12'b0};
    assign rob_full  = (count == (IDX_W+1)'(DEPTH));
    assign issue_tag = tail;
    assign issue_acc = issue_valid && !rob_full;
    assign do_commit = (count != '0) && ready[head];
    assign rd_eff    = (op == OP_BR || op == OP_ST) ? 5'd0 : issue_ins[11:7];

    assign qry_ready_a = busy[qry_tag_a] && ready[qry_tag_a];
    assign qry_ready_b = busy[qry_tag_b] && ready[qry_tag_b];
    assign qry_value_a = value[qry_tag_a];
    assign qry_value_b = value[qry_tag_b];

    // LUI/AUIPC/JAL produce their result at issue and never reach the RS
    always_comb begin
        imm_op  = 1'b1;
        imm_val = '0;
        unique case (1'b1)
            op == OP_LUI:   imm_val = XLEN'(upper);
            op == OP_AUIPC: imm_val = XLEN'(issue_pc + upper);
            op == OP_JAL:   imm_val = XLEN'(issue_pc + 32'd4);
            default:        imm_op  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            is_br            <= '0;
            is_jr            <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest[i]  <= '0;
                value[i] <= '0;
                pc_q[i]  <= '0;
            end
            disp_valid       <= 1'b0;
            disp_ins         <= '0;
            disp_tag         <= '0;
            disp_rd          <= '0;
            disp_is_ls       <= 1'b0;
            commit_valid     <= 1'b0;
            commit_tag       <= '0;
            commit_dest      <= '0;
            commit_value     <= '0;
            commit_pc        <= '0;
            commit_is_branch <= 1'b0;
            commit_is_jalr   <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                busy         <= '0;
                ready        <= '0;
                disp_valid   <= 1'b0;
                commit_valid <= 1'b0;
            end else begin
                disp_valid <= issue_acc && !imm_op;
                if (issue_acc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= imm_op;
                    dest[tail]  <= rd_eff;
                    value[tail] <= imm_val;
                    pc_q[tail]  <= issue_pc;
                    is_br[tail] <= (op == OP_BR);
                    is_jr[tail] <= (op == OP_JALR);
                    tail        <= tail + IDX_W'(1);
                    if (!imm_op) begin
                        disp_ins   <= issue_ins;
                        disp_tag   <= tail;
                        disp_rd    <= rd_eff;
                        disp_is_ls <= (op == OP_LD || op == OP_ST);
                    end
                end
                // later ports overwrite earlier ones on a shared tag
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_valid[p] && busy[wb_tag[p*IDX_W +: IDX_W]]
                        && !ready[wb_tag[p*IDX_W +: IDX_W]]) begin
                        ready[wb_tag[p*IDX_W +: IDX_W]] <= 1'b1;
                        value[wb_tag[p*IDX_W +: IDX_W]] <= wb_value[p*XLEN +: XLEN];
                    end
                end
                commit_valid <= do_commit;
                if (do_commit) begin
                    commit_tag       <= head;
                    commit_dest      <= dest[head];
                    commit_value     <= value[head];
                    commit_pc        <= pc_q[head];
                    commit_is_branch <= is_br[head];
                    commit_is_jalr   <= is_jr[head];
                    busy[head]       <= 1'b0;
                    ready[head]      <= 1'b0;
                    head             <= head + IDX_W'(1);
                end
                unique case ({issue_acc, do_commit})
                    2'b10:   count <= count + (IDX_W+1)'(1);
                    2'b01:   count <= count - (IDX_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed bench for reorder_buffer_mp: immediates, full/stall, multi-port
// writeback priority, wrap-around commit order, freeze and flush.
module tb_reorder_buffer_mp;
    localparam int IDX_W  = 4;
    localparam int NUM_WB = 3;
    localparam int XLEN   = 32;

    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SW    = 32'h0020A023;

    logic                    clk = 1'b0;
    logic                    rst, rdy, issue_valid, flush;
    logic [31:0]             issue_ins, issue_pc;
    logic                    rob_full, disp_valid, disp_is_ls;
    logic [IDX_W-1:0]        issue_tag, disp_tag, commit_tag;
    logic [31:0]             disp_ins, commit_pc;
    logic [4:0]              disp_rd, commit_dest;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*IDX_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_value;
    logic [IDX_W-1:0]        qry_tag_a, qry_tag_b;
    logic                    qry_ready_a, qry_ready_b;
    logic [XLEN-1:0]         qry_value_a, qry_value_b, commit_value;
    logic                    commit_valid, commit_is_branch, commit_is_jalr;
    logic [IDX_W:0]          count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    reorder_buffer_mp dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_ins(issue_ins), .issue_pc(issue_pc),
        .rob_full(rob_full), .issue_tag(issue_tag),
        .disp_valid(disp_valid), .disp_ins(disp_ins), .disp_tag(disp_tag),
        .disp_rd(disp_rd), .disp_is_ls(disp_is_ls),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .qry_tag_a(qry_tag_a), .qry_tag_b(qry_tag_b),
        .qry_ready_a(qry_ready_a), .qry_ready_b(qry_ready_b),
        .qry_value_a(qry_value_a), .qry_value_b(qry_value_b),
        .flush(flush),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_pc(commit_pc), .commit_is_branch(commit_is_branch),
        .commit_is_jalr(commit_is_jalr), .count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input int p, input logic [IDX_W-1:0] t,
                      input logic [XLEN-1:0] v);
        wb_valid[p] = 1'b1;
        wb_tag[p*IDX_W +: IDX_W] = t;
        wb_value[p*XLEN +: XLEN] = v;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_ins = ins;
        issue_pc = pc;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_ins = '0; issue_pc = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0;
        qry_tag_a = '0; qry_tag_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_cv", 64'(commit_valid), 64'h0);
        chk("rst_dv", 64'(disp_valid), 64'h0);
        chk("rst_full", 64'(rob_full), 64'h0);
        chk("rst_itag", 64'(issue_tag), 64'h0);

        // LUI resolves at issue, commits two cycles after presentation
        issue(I_LUI, 32'h100);
        tick();
        issue_valid = 1'b0;
        chk("lui_dv", 64'(disp_valid), 64'h0);
        chk("lui_cnt", 64'(count), 64'h1);
        chk("lui_cv0", 64'(commit_valid), 64'h0);
        tick();
        chk("lui_cv", 64'(commit_valid), 64'h1);
        chk("lui_dest", 64'(commit_dest), 64'h5);
        chk("lui_val", 64'(commit_value), 64'h12345000);
        chk("lui_pc", 64'(commit_pc), 64'h100);
        chk("lui_cnt0", 64'(count), 64'h0);
        tick();
        chk("lui_pulse", 64'(commit_valid), 64'h0);

        issue(I_AUIPC, 32'h1000);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("auipc_val", 64'(commit_value), 64'h2000);
        chk("auipc_tag", 64'(commit_tag), 64'h1);

        issue(I_JAL, 32'h20);
        tick();
        issue_valid = 1'b0;
        chk("jal_dv", 64'(disp_valid), 64'h0);
        tick();
        chk("jal_val", 64'(commit_value), 64'h24);
        chk("jal_dest", 64'(commit_dest), 64'h1);
        chk("jal_dv2", 64'(disp_valid), 64'h0);

        // store: dispatched to LSB with no destination
        issue(I_SW, 32'h30);
        tick();
        issue_valid = 1'b0;
        chk("sw_dv", 64'(disp_valid), 64'h1);
        chk("sw_tag", 64'(disp_tag), 64'h3);
        chk("sw_rd", 64'(disp_rd), 64'h0);
        chk("sw_ls", 64'(disp_is_ls), 64'h1);
        wb(1, 4'd3, 32'h77);
        tick();
        wb_valid = '0;
        chk("sw_dv0", 64'(disp_valid), 64'h0);
        chk("sw_cv0", 64'(commit_valid), 64'h0);
        tick();
        chk("sw_cv", 64'(commit_valid), 64'h1);
        chk("sw_ctag", 64'(commit_tag), 64'h3);
        chk("sw_cdest", 64'(commit_dest), 64'h0);

        // fill to capacity
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue(I_ADD, 32'(i * 4));
            tick();
            if (i == 0) begin
                chk("add_dv", 64'(disp_valid), 64'h1);
                chk("add_tag", 64'(disp_tag), 64'h0);
                chk("add_rd", 64'(disp_rd), 64'h3);
                chk("add_ls", 64'(disp_is_ls), 64'h0);
                chk("add_ins", 64'(disp_ins), 64'(I_ADD));
            end
        end
        chk("full_cnt", 64'(count), 64'h10);
        chk("full_flag", 64'(rob_full), 64'h1);
        chk("full_itag", 64'(issue_tag), 64'h0);
        tick();
        chk("full_ign_dv", 64'(disp_valid), 64'h0);
        chk("full_ign_cnt", 64'(count), 64'h10);
        issue_valid = 1'b0;
        wb(0, 4'd0, 32'h55);
        tick();
        wb_valid = '0;
        chk("full_cv0", 64'(commit_valid), 64'h0);
        chk("full_cnt2", 64'(count), 64'h10);
        issue(I_ADD, 32'h500);
        tick();
        issue_valid = 1'b0;
        chk("full_cv", 64'(commit_valid), 64'h1);
        chk("full_ctag", 64'(commit_tag), 64'h0);
        chk("full_cval", 64'(commit_value), 64'h55);
        chk("full_cnt3", 64'(count), 64'hF);
        chk("full_blk_dv", 64'(disp_valid), 64'h0);
        chk("full_flag0", 64'(rob_full), 64'h0);
        chk("full_itag2", 64'(issue_tag), 64'h0);

        // multi-port writeback priority, no bypass
        qry_tag_a = 4'd3;
        qry_tag_b = 4'd4;
        wb(0, 4'd3, 32'hAAAA);
        wb(2, 4'd3, 32'hBBBB);
        #1;
        chk("qry_nobyp", 64'(qry_ready_a), 64'h0);
        tick();
        wb_valid = '0;
        chk("qry_rdy_a", 64'(qry_ready_a), 64'h1);
        chk("qry_val_a", 64'(qry_value_a), 64'hBBBB);
        chk("qry_rdy_b", 64'(qry_ready_b), 64'h0);
        chk("ooo_cv", 64'(commit_valid), 64'h0);
        wb(0, 4'd1, 32'h11);
        wb(1, 4'd2, 32'h22);
        wb(2, 4'd3, 32'hCCCC);
        tick();
        wb_valid = '0;
        chk("wb_ign", 64'(qry_value_a), 64'hBBBB);
        chk("ooo_cv2", 64'(commit_valid), 64'h0);
        tick();
        chk("ord_t1", 64'(commit_tag), 64'h1);
        chk("ord_v1", 64'(commit_value), 64'h11);
        tick();
        chk("ord_t2", 64'(commit_tag), 64'h2);
        chk("ord_v2", 64'(commit_value), 64'h22);
        tick();
        chk("ord_t3", 64'(commit_tag), 64'h3);
        chk("ord_v3", 64'(commit_value), 64'hBBBB);
        chk("ord_cnt", 64'(count), 64'hC);

        // wrap: steady issue, writeback, commit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 42; c++) begin
            wb_valid = '0;
            issue_valid = (c < 40);
            issue_ins = I_ADD;
            issue_pc = 32'(c * 4);
            if (c >= 1 && c <= 40) wb(0, 4'((c - 1) % 16), 32'(c - 1));
            tick();
            if (c >= 2) begin
                chk("wrap_cv", 64'(commit_valid), 64'h1);
                chk("wrap_tag", 64'(commit_tag), 64'((c - 2) % 16));
                chk("wrap_val", 64'(commit_value), 64'(c - 2));
            end
            if (c >= 1 && c <= 39) chk("wrap_cnt", 64'(count), 64'h2);
        end
        wb_valid = '0;
        issue_valid = 1'b0;
        tick();
        chk("wrap_end_cv", 64'(commit_valid), 64'h0);
        chk("wrap_end_cnt", 64'(count), 64'h0);

        // eight live entries, freeze, then flush
        for (int i = 0; i < 8; i++) begin
            issue(I_ADD, 32'(i * 4));
            tick();
        end
        chk("fl_cnt8", 64'(count), 64'h8);
        chk("fl_dtag", 64'(disp_tag), 64'hF);
        rdy = 1'b0;
        wb(0, 4'd8, 32'h99);
        tick();
        chk("frz_dv", 64'(disp_valid), 64'h1);
        chk("frz_cnt", 64'(count), 64'h8);
        qry_tag_a = 4'd8;
        #1;
        chk("frz_wb", 64'(qry_ready_a), 64'h0);
        rdy = 1'b1;
        issue_valid = 1'b0;
        tick();
        wb_valid = '0;
        chk("fl_rdy8", 64'(qry_ready_a), 64'h1);
        flush = 1'b1;
        issue(I_ADD, 32'h800);
        wb(0, 4'd9, 32'h1);
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        wb_valid = '0;
        qry_tag_b = 4'd9;
        #1;
        chk("fl_cnt", 64'(count), 64'h0);
        chk("fl_cv", 64'(commit_valid), 64'h0);
        chk("fl_dv", 64'(disp_valid), 64'h0);
        chk("fl_itag", 64'(issue_tag), 64'h0);
        chk("fl_q8", 64'(qry_ready_a), 64'h0);
        chk("fl_q9", 64'(qry_ready_b), 64'h0);
        tick();
        chk("fl_cv2", 64'(commit_valid), 64'h0);
        issue(I_LUI, 32'h40);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("post_cv", 64'(commit_valid), 64'h1);
        chk("post_tag", 64'(commit_tag), 64'h0);
        chk("post_pc", 64'(commit_pc), 64'h40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
